// File: rtl/serial_barrel_shifter.sv
// serial_barrel_shifter
//   Multi-cycle ARM shifter-operand unit. Applies LSL/LSR/ASR/ROR by a
//   register-specified amount to a WIDTH-bit operand, one bit position per
//   clock, and produces the shifter carry-out. The amount is reduced on
//   accept to an iteration count so that ARM's large-amount results fall out
//   of plain single-bit steps.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active high (wins over start)
//   start      request, accepted only when busy==0
//   shift_in   operand, sampled on accepted start
//   shift_op   00 LSL, 01 LSR, 10 ASR, 11 ROR, sampled on accepted start
//   shift_amt  shift amount, sampled on accepted start
//   carry_in   current C flag, sampled on accepted start
//   busy       high while shifting
//   done       one-cycle pulse, shift_out/carry_out valid
//   shift_out  result, held until the next accepted start
//   carry_out  shifter carry-out, held with shift_out
module serial_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [1:0]       shift_op,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int ROT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Number of single-bit steps. Linear shifts saturate at WIDTH+1 steps:
  // by then the result and carry no longer change (zero / sign fill). A
  // rotate only needs the amount modulo WIDTH, with a full turn kept as
  // WIDTH steps so the carry ends up as the operand's top bit.
  function automatic logic [CNT_W-1:0] iter_count(input logic [1:0]       op,
                                                  input logic [AMT_W-1:0] amt);
    logic [ROT_W-1:0] rot;
    rot = amt[ROT_W-1:0];
    if (amt == '0)
      return '0;
    else if (op == OP_ROR)
      return (rot == '0) ? CNT_W'(WIDTH) : CNT_W'(rot);
    else if (amt > AMT_W'(WIDTH))
      return CNT_W'(WIDTH + 1);
    else
      return CNT_W'(amt);
  endfunction

  // One bit position of the selected shift. Returns {carry, result}.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] val);
    logic [WIDTH:0] res;
    case (op)
      OP_LSL:  res = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
      OP_LSR:  res = {val[0], 1'b0, val[WIDTH-1:1]};
      OP_ASR:  res = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
      default: res = {val[0], val[0], val[WIDTH-1:1]};
    endcase
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] n_iter;
  logic [WIDTH:0]   stepped;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_d   = out_q;
    carry_d = carry_q;
    n_iter  = iter_count(shift_op, shift_amt);
    stepped = shift_step(op_q, out_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d    = shift_op;
          out_d   = shift_in;
          carry_d = carry_in;
          cnt_d   = n_iter;
          state_d = (n_iter == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // start is deliberately not looked at here
        carry_d = stepped[WIDTH];
        out_d   = stepped[WIDTH-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_LSL;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_out = out_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_barrel_shifter.sv
// Directed bench for serial_barrel_shifter: a table of shift vectors with
// hand-computed results and latencies, plus sequences for start-while-busy,
// start-in-DONE and reset-mid-shift.
module tb_serial_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] shift_in;
  logic [1:0]  shift_op;
  logic [7:0]  shift_amt;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] shift_out;
  logic        carry_out;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_barrel_shifter #(.WIDTH(32), .AMT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .shift_in  (shift_in),
    .shift_op  (shift_op),
    .shift_amt (shift_amt),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [7:0]  amt;
    logic [31:0] din;
    logic        cin;
    logic [31:0] exp_out;
    logic        exp_c;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Called at the negedge of cycle cyc0 (first cycle after the accept edge).
  // Walks forward until done, returning the cycle index of the done pulse
  // (0 on timeout) and whether busy stayed high on every cycle before it.
  task automatic wait_done(input int cyc0, output int lat, output bit busy_ok);
    int cyc;
    cyc     = cyc0;
    lat     = 0;
    busy_ok = 1'b1;
    while (cyc <= 40) begin
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] amt,
                       input logic [31:0] din, input logic cin);
    start     = 1'b1;
    shift_op  = op;
    shift_amt = amt;
    shift_in  = din;
    carry_in  = cin;
    @(negedge clk);
    // Scramble the operand inputs: only the latched copies may matter.
    start     = 1'b0;
    shift_op  = 2'($urandom);
    shift_amt = 8'($urandom);
    shift_in  = $urandom;
    carry_in  = 1'($urandom);
  endtask

  task automatic check_result(input string name, input int lat, input bit busy_ok,
                              input logic [31:0] exp_out, input logic exp_c,
                              input int exp_lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({name, " out"}, shift_out, exp_out);
    chk({name, " carry"}, {31'd0, carry_out}, {31'd0, exp_c});
    @(negedge clk);
    chk({name, " done_single"}, {31'd0, done}, 32'd0);
    chk({name, " out_held"}, shift_out, exp_out);
  endtask

  initial begin
    int  lat;
    bit  bok;

    vecs.push_back('{"lsl1by4",      2'b00, 8'd4,   32'h0000_0001, 1'b1, 32'h0000_0010, 1'b0, 5});
    vecs.push_back('{"lsr_by32",     2'b01, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 33});
    vecs.push_back('{"lsr_by33",     2'b01, 8'd33,  32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 34});
    vecs.push_back('{"asr_by200",    2'b10, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 34});
    vecs.push_back('{"asr_by1",      2'b10, 8'd1,   32'h4000_0000, 1'b1, 32'h2000_0000, 1'b0, 2});
    vecs.push_back('{"ror_by1",      2'b11, 8'd1,   32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 2});
    vecs.push_back('{"ror_by64",     2'b11, 8'd64,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 33});
    vecs.push_back('{"lsl_amt0",     2'b00, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1});
    vecs.push_back('{"lsr_amt0",     2'b01, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1});
    vecs.push_back('{"asr_amt0",     2'b10, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1});
    vecs.push_back('{"ror_amt0",     2'b11, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1});
    vecs.push_back('{"lsl_by32",     2'b00, 8'd32,  32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 33});
    vecs.push_back('{"lsl_f0by4",    2'b00, 8'd4,   32'hF000_0000, 1'b0, 32'h0000_0000, 1'b1, 5});
    vecs.push_back('{"lsr_fby3",     2'b01, 8'd3,   32'h0000_000F, 1'b0, 32'h0000_0001, 1'b1, 4});
    vecs.push_back('{"ror_by8",      2'b11, 8'd8,   32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0, 9});
    vecs.push_back('{"ror_by36",     2'b11, 8'd36,  32'h1234_5678, 1'b0, 32'h8123_4567, 1'b1, 5});
    vecs.push_back('{"asr_pos_by40", 2'b10, 8'd40,  32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34});

    rst       = 1'b1;
    start     = 1'b0;
    shift_in  = 32'hA5A5_A5A5;
    shift_op  = 2'b00;
    shift_amt = 8'd0;
    carry_in  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset out", shift_out, 32'd0);
    chk("reset carry", {31'd0, carry_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].cin);
      wait_done(1, lat, bok);
      check_result(vecs[i].name, lat, bok, vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_lat);
    end

    // start pulsed during SHIFT must be ignored
    issue(2'b00, 8'd4, 32'h0000_0001, 1'b1);
    start     = 1'b1;
    shift_op  = 2'b01;
    shift_amt = 8'd0;
    shift_in  = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat, bok);
    check_result("ign_start", lat, bok, 32'h0000_0010, 1'b0, 5);

    // start accepted in the DONE cycle: back-to-back operations
    issue(2'b01, 8'd0, 32'hCAFE_0001, 1'b0);
    wait_done(1, lat, bok);
    chk("b2b first latency", 32'(lat), 32'd1);
    chk("b2b first out", shift_out, 32'hCAFE_0001);
    issue(2'b00, 8'd1, 32'h0000_0001, 1'b1);
    wait_done(1, lat, bok);
    check_result("b2b second", lat, bok, 32'h0000_0002, 1'b0, 2);

    // rst mid-SHIFT, together with start: everything cleared, no done
    issue(2'b10, 8'd200, 32'h8000_0000, 1'b1);
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    start     = 1'b1;
    shift_amt = 8'd0;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst out", shift_out, 32'd0);
    chk("midrst carry", {31'd0, carry_out}, 32'd0);
    bok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bok = 1'b0;
    end
    chk("midrst quiet", {31'd0, bok}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
